div_seq_32_bit: RTL and testbench

DIV_SEQ_32_BIT -- requirements
Module: div_seq_32_bit

---
 rtl/div_pkg.sv | 14 +
 rtl/add_rca_32_bit.sv | 23 ++
 rtl/div_seq_32_bit.sv | 125 ++++++++++++
 tb/tb_div_seq_32_bit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/add_rca_32_bit.sv
// 32-bit ripple-carry adder; the divider uses it as a subtractor (y = ~b, ci = 1).
module add_rca_32_bit (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [32:0] carry;

  assign carry[0] = ci;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_bit
      assign s[gi]       = x[gi] ^ y[gi] ^ carry[gi];
      assign carry[gi+1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign co = carry[32];

endmodule

// File: rtl/div_seq_32_bit.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, 32 RUN cycles.
module div_seq_32_bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Reset asserts asynchronously but releases only after two clean edges.
  logic [1:0] rst_sync_reg;
  logic       run_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign run_en = rst_sync_reg[1];

  div_state_t state_reg, state_next;
  logic       accept;
  logic [4:0] cnt_reg;
  logic       cnt_zero;

  assign cnt_zero = (cnt_reg == 5'd0);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start && run_en) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_zero) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state_reg <= IDLE;
    else if (!run_en) state_reg <= IDLE;
    else              state_reg <= state_next;
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

  // Working registers: partial remainder and the dividend that shifts into the quotient.
  logic [WIDTH-1:0] acc_reg, q_reg, dvs_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             dbz_reg;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic             take;
  logic [WIDTH-1:0] acc_next, q_next;

  assign trial = {acc_reg, q_reg[WIDTH-1]};

  add_rca_32_bit u_sub (
    .x  (trial[WIDTH-1:0]),
    .y  (~dvs_reg),
    .ci (1'b1),
    .s  (diff),
    .co (no_borrow)
  );

  // trial[WIDTH] set means the trial exceeds any WIDTH-bit divisor.
  assign take     = trial[WIDTH] | no_borrow;
  assign acc_next = take ? diff : trial[WIDTH-1:0];
  assign q_next   = {q_reg[WIDTH-2:0], take};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      q_reg         <= '0;
      dvs_reg       <= '0;
      cnt_reg       <= 5'd0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (accept) begin
      acc_reg <= '0;
      q_reg   <= dividend;
      dvs_reg <= divisor;
      cnt_reg <= 5'd31;
      dbz_reg <= 1'b0;
      if (divisor == '0) begin
        quotient_reg  <= DIV0_QUOTIENT;
        remainder_reg <= dividend;
        dbz_reg       <= 1'b1;
      end
    end else if (state_reg == RUN) begin
      acc_reg <= acc_next;
      q_reg   <= q_next;
      cnt_reg <= cnt_reg - 5'd1;
      if (cnt_zero) begin
        quotient_reg  <= q_next;
        remainder_reg <= acc_next;
      end
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_seq_32_bit.sv
// Self-checking bench: directed table, multi-cycle corner sequences, random vs. arithmetic model.
module tb_div_seq_32_bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  div_seq_32_bit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
    int          bcnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  // Launch one division; lat is the edge index (after the accepting edge) on which done is seen.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic z, output int lat, output int bcnt);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      bcnt += int'(busy);
      @(posedge clk);
      #1;
      lat++;
    end
    lat = lat + 1;
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  vec_t        vecs[8];
  logic [31:0] q, r, prev_q, prev_r;
  logic        z;
  int          lat, bcnt;

  initial begin
    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 32};
    vecs[1] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd1,          32'h7FFF_FFFF, 1'b0, 33, 32};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,          1'b0, 33, 32};
    vecs[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF, 32'd5,          1'b1, 1,  0};
    vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33, 32};
    vecs[5] = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0, 33, 32};
    vecs[6] = '{32'd1,          32'hFFFF_FFFF, 32'd0,          32'd1,          1'b0, 33, 32};
    vecs[7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,          32'hFFFF_FFFE, 1'b0, 33, 32};

    // Reset state
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    repeat (3) @(posedge clk);
    release_reset();

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, q, r, z, lat, bcnt);
      $display("vec %0d: %0h / %0h -> q=%0h r=%0h dbz=%0b lat=%0d busy=%0d",
               i, vecs[i].a, vecs[i].b, q, r, z, lat, bcnt);
      chk("vec_q", q, vecs[i].q);
      chk("vec_r", r, vecs[i].r);
      chk("vec_dbz", {31'd0, z}, {31'd0, vecs[i].z});
      chk("vec_lat", 32'(lat), 32'(vecs[i].lat));
      chk("vec_busy_cycles", 32'(bcnt), 32'(vecs[i].bcnt));
    end
    prev_q = vecs[7].q;
    prev_r = vecs[7].r;

    // Start during RUN is ignored; start held through done gives a back-to-back run
    @(negedge clk);
    dividend = 32'd3;
    divisor  = 32'd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_q_hold", quotient, prev_q);
    chk("run_r_hold", remainder, prev_r);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("ignore-start: 3 / 10 -> q=%0h r=%0h", quotient, remainder);
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_q", quotient, 32'd0);
    chk("ign_r", remainder, 32'd3);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    lat  = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    lat = lat + 1;
    $display("back-to-back: 50 / 5 -> q=%0h r=%0h lat=%0d", quotient, remainder, lat);
    chk("b2b_q", quotient, 32'd10);
    chk("b2b_r", remainder, 32'd0);
    chk("b2b_lat", 32'(lat), 32'd33);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    $display("mid-run reset: busy=%0b done=%0b q=%0h r=%0h", busy, done, quotient, remainder);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_dbz",  {31'd0, div_by_zero}, 32'd0);
    chk("mrst_q", quotient, 32'd0);
    chk("mrst_r", remainder, 32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    run_div(32'd9, 32'd4, q, r, z, lat, bcnt);
    $display("post-reset: 9 / 4 -> q=%0h r=%0h lat=%0d", q, r, lat);
    chk("prst_q", q, 32'd2);
    chk("prst_r", r, 32'd1);
    chk("prst_lat", 32'(lat), 32'd33);

    // Random nonzero operands against plain arithmetic
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b, eq, er;
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom | 32'h8000_0000;
      endcase
      if (b == 32'd0) b = 32'd1;
      eq = a / b;
      er = a % b;
      run_div(a, b, q, r, z, lat, bcnt);
      $display("rand %0d: %08h / %08h -> q=%08h r=%08h", i, a, b, q, r);
      chk("rand_q", q, eq);
      chk("rand_r", r, er);
      chk("rand_lat", 32'(lat), 32'd33);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
